// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues req/ack fetches to a multi-cycle
// instruction memory and presents each fetched instruction to decode with a
// valid/stall handshake. A redirect that lands while a fetch is outstanding is
// remembered and the returning data is discarded.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch/squash/stall counters.
module fetch_sequencer #(
    parameter int              WORD      = 64,
    parameter int              INSTR_LEN = 32,
    parameter logic [WORD-1:0] RESET_PC  = '0,
    parameter int              PC_INC    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD-1:0]      branch_target,
    input  logic                 pc_src,
    input  logic                 stall,
    output logic                 imem_req,
    output logic [WORD-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_LEN-1:0] imem_rdata,
    output logic [WORD-1:0]      cur_pc_if,
    output logic [INSTR_LEN-1:0] instruction_if,
    output logic                 valid_if
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_count,
    output logic [31:0]          squash_count,
    output logic [31:0]          stall_count
`endif
);

    localparam logic [WORD-1:0] PC_STEP = WORD'(PC_INC);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_OUT   = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD-1:0]        pc_q, pc_d;
    logic                   redir_pend_q, redir_pend_d;
    logic [WORD-1:0]        pend_target_q, pend_target_d;
    logic [WORD-1:0]        cur_pc_q, cur_pc_d;
    logic [INSTR_LEN-1:0]   instr_q, instr_d;
    logic                   valid_q, valid_d;

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            redir_pend_q  <= 1'b0;
            pend_target_q <= '0;
            cur_pc_q      <= '0;
            instr_q       <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redir_pend_q  <= redir_pend_d;
            pend_target_q <= pend_target_d;
            cur_pc_q      <= cur_pc_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
        end
    end

    // Next-state and next-PC selection; the PC only moves on delivery or redirect.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redir_pend_d  = redir_pend_q;
        pend_target_d = pend_target_q;
        cur_pc_d      = cur_pc_q;
        instr_d       = instr_q;
        valid_d       = valid_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    if (redir_pend_q || pc_src) begin
                        // Data belongs to a stale address: drop it and refetch.
                        pc_d         = pc_src ? branch_target : pend_target_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        instr_d  = imem_rdata;
                        cur_pc_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = S_OUT;
                    end
                end else if (pc_src) begin
                    // Address must stay stable until ack, so park the target.
                    redir_pend_d  = 1'b1;
                    pend_target_d = branch_target;
                end
            end
            S_OUT: begin
                if (pc_src) begin
                    valid_d = 1'b0;
                    pc_d    = branch_target;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs: request is gated by reset so it drops without waiting for a clock.
    always_comb begin
        imem_req       = (state_q == S_FETCH) && !reset;
        imem_addr      = pc_q;
        cur_pc_if      = cur_pc_q;
        instruction_if = instr_q;
        valid_if       = valid_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic        deliver_evt, squash_evt, stall_evt;
    logic [31:0] fetch_cnt_q, squash_cnt_q, stall_cnt_q;

    // Event decode for the performance counters.
    always_comb begin
        deliver_evt = (state_q == S_FETCH) && imem_ack && !redir_pend_q && !pc_src;
        squash_evt  = (state_q == S_FETCH) && imem_ack && (redir_pend_q || pc_src);
        stall_evt   = (state_q == S_OUT) && stall && !pc_src;
    end

    // Free-running wrap-around counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            squash_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (deliver_evt) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (squash_evt)  squash_cnt_q <= squash_cnt_q + 32'd1;
            if (stall_evt)   stall_cnt_q  <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign squash_count = squash_cnt_q;
    assign stall_count  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios with literal expectations
// followed by randomized stimulus against a transaction-level model.
module tb_fetch_sequencer;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [WORD-1:0]      branch_target;
    logic                 pc_src;
    logic                 stall;
    logic                 imem_req;
    logic [WORD-1:0]      imem_addr;
    logic                 imem_ack;
    logic [INSTR_LEN-1:0] imem_rdata;
    logic [WORD-1:0]      cur_pc_if;
    logic [INSTR_LEN-1:0] instruction_if;
    logic                 valid_if;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]          fetch_count, squash_count, stall_count;
`endif

    int tests = 0;
    int fails = 0;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .branch_target  (branch_target),
        .pc_src         (pc_src),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .cur_pc_if      (cur_pc_if),
        .instruction_if (instruction_if),
        .valid_if       (valid_if)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .squash_count   (squash_count),
        .stall_count    (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: data is 0xAAAA0000 + addr; ack after mem_cfg wait cycles
    // (or a random 0..3 when mem_cfg is negative).
    int mem_cnt;
    int mem_cfg;
    int rnd_delay;
    assign imem_rdata = 32'hAAAA0000 + imem_addr[31:0];
    assign imem_ack   = imem_req && (mem_cnt >= ((mem_cfg >= 0) ? mem_cfg : rnd_delay));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cnt   <= 0;
            rnd_delay <= 0;
        end else if (imem_req) begin
            if (imem_ack) begin
                mem_cnt   <= 0;
                rnd_delay <= int'($urandom_range(0, 3));
            end else begin
                mem_cnt <= mem_cnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: what fetch should be doing, expressed as a transaction view.
    logic            m_present;     // an instruction is being shown to decode
    logic [63:0]     m_addr;        // address the next fetch must use
    logic            m_pend;        // redirect waiting for the outstanding ack
    logic [63:0]     m_tgt;
    logic [63:0]     m_pc_if;
    logic [31:0]     m_ins;
    int              m_fetch, m_squash, m_stall, n_deliv;

    initial begin
        n_deliv = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_present = 1'b0; m_addr = 64'h0; m_pend = 1'b0; m_tgt = 64'h0;
                m_pc_if = 64'h0; m_ins = 32'h0;
                m_fetch = 0; m_squash = 0; m_stall = 0;
                chk("m_req_in_reset", {63'b0, imem_req}, 64'd0);
                chk("m_valid_in_reset", {63'b0, valid_if}, 64'd0);
            end else begin
                chk("m_req", {63'b0, imem_req}, {63'b0, !m_present});
                chk("m_valid", {63'b0, valid_if}, {63'b0, m_present});
                if (!m_present) chk("m_addr", imem_addr, m_addr);
                if (m_present) begin
                    chk("m_cur_pc", cur_pc_if, m_pc_if);
                    chk("m_instr", {32'b0, instruction_if}, {32'b0, m_ins});
                end
`ifdef FETCH_PERF_CNT_EN
                chk("m_fetch_cnt", {32'b0, fetch_count}, 64'(unsigned'(m_fetch)));
                chk("m_squash_cnt", {32'b0, squash_count}, 64'(unsigned'(m_squash)));
                chk("m_stall_cnt", {32'b0, stall_count}, 64'(unsigned'(m_stall)));
`endif
                // Advance to what the next edge must produce.
                if (!m_present) begin
                    if (imem_ack) begin
                        if (pc_src || m_pend) begin
                            m_addr = pc_src ? branch_target : m_tgt;
                            m_pend = 1'b0;
                            m_squash++;
                        end else begin
                            m_present = 1'b1;
                            m_pc_if   = m_addr;
                            m_ins     = 32'hAAAA0000 + m_addr[31:0];
                            m_addr    = m_addr + 64'd4;
                            m_fetch++;
                            n_deliv++;
                            $display("[TB] deliver pc=%h instr=%h", m_pc_if, m_ins);
                        end
                    end else if (pc_src) begin
                        m_pend = 1'b1;
                        m_tgt  = branch_target;
                    end
                end else begin
                    if (pc_src) begin
                        m_present = 1'b0;
                        m_addr    = branch_target;
                    end else if (!stall) begin
                        m_present = 1'b0;
                    end else begin
                        m_stall++;
                    end
                end
            end
        end
    end

    // One cycle: drive inputs just after the edge, return at the following negedge.
    task automatic cyc(input bit ps, input logic [63:0] bt, input bit st, input int dly);
        @(posedge clk);
        #1;
        pc_src = ps; branch_target = bt; stall = st; mem_cfg = dly;
        @(negedge clk);
    endtask

    // Async reset pulse started between edges; outputs must drop with no edge.
    task automatic reset_pulse(input string nm);
        #1 reset = 1'b1;
        #1;
        chk({nm, "_req_async"}, {63'b0, imem_req}, 64'd0);
        chk({nm, "_valid_async"}, {63'b0, valid_if}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; pc_src = 1'b0; stall = 1'b0; mem_cfg = 0;
        @(negedge clk);
        chk({nm, "_req_after"}, {63'b0, imem_req}, 64'd1);
        chk({nm, "_addr_after"}, imem_addr, 64'h0);
    endtask

    logic [63:0] a;
    logic [63:0] bt_r;

    initial begin
        reset = 1'b1; pc_src = 1'b0; stall = 1'b0; branch_target = '0; mem_cfg = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {63'b0, imem_req}, 64'd0);
        chk("rst_valid", {63'b0, valid_if}, 64'd0);
        chk("rst_cur_pc", cur_pc_if, 64'h0);
        chk("rst_instr", {32'b0, instruction_if}, 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t1_req0", {63'b0, imem_req}, 64'd1);
        chk("t1_addr0", imem_addr, 64'h0);

        // Zero-wait sequential fetch.
        cyc(0, 0, 0, 0);
        chk("t1_valid0", {63'b0, valid_if}, 64'd1);
        chk("t1_pc0", cur_pc_if, 64'h0);
        chk("t1_instr0", {32'b0, instruction_if}, 64'hAAAA0000);
        chk("t1_model_pc0", m_pc_if, 64'h0);
        cyc(0, 0, 0, 0); chk("t1_addr4", imem_addr, 64'h4);
        chk("t1_req4", {63'b0, imem_req}, 64'd1);
        cyc(0, 0, 0, 0); chk("t1_pc4", cur_pc_if, 64'h4);
        cyc(0, 0, 0, 0); chk("t1_addr8", imem_addr, 64'h8);
        cyc(0, 0, 0, 0); chk("t1_instr8", {32'b0, instruction_if}, 64'hAAAA0008);
        cyc(0, 0, 0, 0); chk("t1_addrC", imem_addr, 64'hC);
        cyc(0, 0, 0, 0); chk("t1_pcC", cur_pc_if, 64'hC);

        // Three-cycle memory at 0x10.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 2);
            chk("t2_addr10", imem_addr, 64'h10);
            chk("t2_req", {63'b0, imem_req}, 64'd1);
            chk("t2_valid0", {63'b0, valid_if}, 64'd0);
        end
        cyc(0, 0, 0, 0);
        chk("t2_valid", {63'b0, valid_if}, 64'd1);
        chk("t2_pc10", cur_pc_if, 64'h10);
        chk("t2_noreq", {63'b0, imem_req}, 64'd0);
        chk("t2_model_pc", m_pc_if, 64'h10);

        // Walk up to 0x20 and stall there.
        a = 64'h14;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0); chk("t3_walk_addr", imem_addr, a);
            cyc(0, 0, 0, 0); chk("t3_walk_pc", cur_pc_if, a);
            a = a + 64'd4;
        end
        cyc(0, 0, 0, 0); chk("t3_addr20", imem_addr, 64'h20);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0);
            chk("t3_stall_valid", {63'b0, valid_if}, 64'd1);
            chk("t3_stall_pc", cur_pc_if, 64'h20);
            chk("t3_stall_instr", {32'b0, instruction_if}, 64'hAAAA0020);
            chk("t3_stall_noreq", {63'b0, imem_req}, 64'd0);
        end
        cyc(0, 0, 0, 0); chk("t3_hold_pc", cur_pc_if, 64'h20);
        cyc(0, 0, 0, 0); chk("t3_addr24", imem_addr, 64'h24);

        // Redirect out of OUT to 0x8, then a redirect during a slow fetch of 0x8.
        cyc(1, 64'h8, 0, 2); chk("t4_pc24", cur_pc_if, 64'h24);
        cyc(0, 0, 0, 2);         chk("t4_addr8_c0", imem_addr, 64'h8);
        cyc(1, 64'h400, 0, 2);   chk("t4_addr8_c1", imem_addr, 64'h8);
        cyc(0, 0, 0, 2);         chk("t4_addr8_c2", imem_addr, 64'h8);
        chk("t4_novalid", {63'b0, valid_if}, 64'd0);
        cyc(0, 0, 0, 0);         chk("t4_addr400", imem_addr, 64'h400);
        chk("t4_novalid2", {63'b0, valid_if}, 64'd0);

        // Redirect and stall together while presenting 0x400.
        cyc(1, 64'h80, 1, 0);    chk("t4_pc400", cur_pc_if, 64'h400);
        chk("t4_instr400", {32'b0, instruction_if}, 64'hAAAA0400);
        cyc(0, 0, 0, 0);         chk("t5_valid_drop", {63'b0, valid_if}, 64'd0);
        chk("t5_addr80", imem_addr, 64'h80);

        // Address wrap at the top of the space.
        cyc(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0); chk("t5_pc80", cur_pc_if, 64'h80);
        cyc(0, 0, 0, 0); chk("t6_addr_max", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 0, 0, 3); chk("t6_pc_max", cur_pc_if, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_instr_max", {32'b0, instruction_if}, 64'hAAA9FFFC);
        cyc(0, 0, 0, 3); chk("t6_wrap_addr", imem_addr, 64'h0);
        cyc(0, 0, 0, 3); chk("t6_wait_req", {63'b0, imem_req}, 64'd1);

        // Reset while waiting on the memory.
        reset_pulse("t7");
        cyc(0, 0, 0, 0); chk("t7_pc0", cur_pc_if, 64'h0);
        chk("t7_valid", {63'b0, valid_if}, 64'd1);

        // Randomized traffic against the model.
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       bt_r = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
                1:       bt_r = {32'h0, $urandom} & ~64'h3;
                default: bt_r = {$urandom, $urandom} & ~64'h3;
            endcase
            cyc(($urandom_range(0, 5) == 0), bt_r, ($urandom_range(0, 2) == 0), -1);
            if (i == 1500) reset_pulse("rnd_rst");
        end
        chk("rnd_progress", {63'b0, (n_deliv > 100)}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the instruction fetch stage. Owns the PC, issues requests to a multi-cycle instruction memory over a req/ack handshake, and presents fetched instructions to decode with a valid/stall handshake. Handles branch redirects, including squashing an in-flight fetch whose address has been made stale by a redirect. Sits between the branch-resolution logic (branch_target/pc_src) and the IF/ID boundary.

Parameters:
WORD, 64, PC and address width
INSTR_LEN, 32, instruction width
RESET_PC, 0, PC value loaded on reset
PC_INC, 4, sequential PC increment

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
branch_target  input  WORD  redirect address, valid when pc_src=1
pc_src  input  1  redirect request, single-cycle, level-sampled each edge
stall  input  1  decode not ready; hold presented instruction
imem_req  output  1  instruction memory request
imem_addr  output  WORD  request address, stable while imem_req=1
imem_ack  input  1  memory response valid; completes current request
imem_rdata  input  INSTR_LEN  memory read data, valid with imem_ack
cur_pc_if  output  WORD  PC of presented instruction
instruction_if  output  INSTR_LEN  presented instruction
valid_if  output  1  instruction_if/cur_pc_if valid

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=FETCH, redir_pend=0, pend_target=0, cur_pc_if=0, instruction_if=0, valid_if=0. imem_req is 0 while reset is high; it is 1 the first cycle after release, with imem_addr=RESET_PC.
- Reset mid-request abandons the request. Any ack arriving after release that belongs to the abandoned request is not tracked; the memory must drop its request on reset.
- States: FETCH, OUT.
- FETCH: imem_req=1, imem_addr=pc (registered; no change while the request is outstanding). valid_if=0.
  - ack=1, no redir_pend, pc_src=0: register instruction_if=imem_rdata, cur_pc_if=pc, valid_if=1; pc<=pc+PC_INC; go to OUT.
  - ack=1 with redir_pend=1 or pc_src=1: discard data. pc<=branch_target if pc_src=1, else pend_target. Clear redir_pend, stay in FETCH. The next cycle starts a new request at the new pc.
  - ack=0, pc_src=1: redir_pend<=1, pend_target<=branch_target. A later redirect overwrites the target (last wins). imem_addr is unchanged.
  - ack=0, pc_src=0: wait, with no timeout.
- OUT: imem_req=0; outputs held.
  - pc_src=1 (priority over stall): valid_if<=0, pc<=branch_target, go to FETCH.
  - stall=0: instruction is consumed this edge; valid_if<=0, go to FETCH.
  - stall=1: hold all outputs and pc.
- Latency: ack in cycle N gives valid_if=1 in cycle N+1. With a zero-wait memory (ack in the cycle req rises), peak throughput is 1 instruction per 2 cycles.
- Arithmetic: pc+PC_INC is modulo 2^WORD. The maximum address wraps to 0 silently.
- The PC is never speculatively advanced past an unconsumed instruction.

Optional Feature:
FETCH_PERF_CNT_EN. When defined, adds three 32-bit outputs:
- fetch_count: increments on each delivered instruction (FETCH->OUT without squash).
- squash_count: increments on each discarded ack.
- stall_count: increments on each OUT cycle with stall=1 and pc_src=0.
All three reset to 0, wrap on overflow, and are unaffected by redirects. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory returning 0xAAAA0000+addr, stall=0 -> imem_addr sequence 0,4,8; valid_if pulses every 2nd cycle; cur_pc_if 0,4,8 with matching instruction_if.
- Memory with 3-cycle ack delay -> imem_addr held at 0x10 for all 3 cycles; valid_if rises the cycle after ack; no second request until OUT exits.
- stall=1 for 4 cycles in OUT at pc 0x20 -> valid_if, cur_pc_if=0x20 and instruction_if constant; imem_req=0; next request at 0x24 after stall drops.
- pc_src=1, branch_target=0x400, raised 1 cycle into a 3-cycle fetch of 0x8 -> ack data discarded, valid_if stays 0, next imem_addr=0x400; first valid cur_pc_if=0x400.
- In OUT, pc_src=1 and stall=1 together with target 0x80 -> valid_if drops next cycle; next request at 0x80.
- pc=0xFFFF_FFFF_FFFF_FFFC delivered -> next imem_addr=0x0. Async reset asserted mid-wait -> imem_req and valid_if go to 0 immediately without a clock edge.
